// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one pipelined signed 16x16 multiplier
// among NUM_REQ requesters, with a tag pipeline routing each product back to its owner.
module mult_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 6,
  parameter int ID_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [15:0]             mul_a,
  output logic [15:0]             mul_b,
  input  logic [31:0]             mul_c,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy
);
  logic [ID_W-1:0]    ptr_q, ptr_d, gnt_id;
  logic               gnt_any;
  logic [ID_W:0]      idx_s;
  logic [15:0]        a_arr [NUM_REQ];
  logic [15:0]        b_arr [NUM_REQ];
  logic [15:0]        mul_a_q, mul_b_q, mul_a_d, mul_b_d;
  logic [MUL_LATENCY:0] tv_q;
  logic [ID_W-1:0]    tid_q [MUL_LATENCY+1];
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [31:0]        rsp_data_q;

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[16*g +: 16];
    assign b_arr[g] = req_b[16*g +: 16];
  end

  // Search starts at ptr and wraps; the first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, ptr_q} + (ID_W+1)'(k);
      idx_s = idx_s >= (ID_W+1)'(NUM_REQ) ? idx_s - (ID_W+1)'(NUM_REQ) : idx_s;
      if (!gnt_any && req_valid[idx_s[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx_s[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d   = gnt_any ? (gnt_id == ID_W'(NUM_REQ-1) ? '0 : gnt_id + ID_W'(1)) : ptr_q;
    mul_a_d = gnt_any ? a_arr[gnt_id] : '0;
    mul_b_d = gnt_any ? b_arr[gnt_id] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tv_q        <= '0;
      for (int k = 0; k <= MUL_LATENCY; k++) tid_q[k] <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      tv_q     <= {tv_q[MUL_LATENCY-1:0], gnt_any};
      tid_q[0] <= gnt_id;
      for (int k = 1; k <= MUL_LATENCY; k++) tid_q[k] <= tid_q[k-1];
      if (tv_q[MUL_LATENCY]) begin
        rsp_data_q <= mul_c;
        rsp_id_q   <= tid_q[MUL_LATENCY];
      end
      rsp_valid_q <= tv_q[MUL_LATENCY] ? NUM_REQ'(1) << tid_q[MUL_LATENCY] : '0;
    end
  end

  assign req_ready = gnt_any ? NUM_REQ'(1) << gnt_id : '0;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = |tv_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: random and directed stimulus against a queue-based model
// of round-robin grants and fixed-latency product return.
module tb_mult_share_arbiter;
  localparam int N = 4;
  localparam int L = 6;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a = '0;
  logic [16*N-1:0] req_b = '0;
  logic [15:0]     mul_a, mul_b;
  logic [31:0]     mul_c;
  logic [N-1:0]    rsp_valid;
  logic [W-1:0]    rsp_id;
  logic [31:0]     rsp_data;
  logic            busy;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L), .ID_W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  // Stand-in for the external multiplier: never reset, so stale products linger.
  logic signed [31:0] mpipe [L] = '{default: 32'sd0};
  always @(posedge clk) begin
    mpipe[0] <= $signed(mul_a) * $signed(mul_b);
    for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_c = mpipe[L-1];

  int vectors = 0;
  int errs = 0;
  int ptr_m = 0;
  int edge_n = 0;
  int exp_gnt = -1;
  int load = 0;
  int drop = 0;
  int acc_e[$], acc_i[$], acc_p[$];
  int glog[$];
  int rl_e[$], rl_id[$], rl_d[$], rl_v[$];
  logic [15:0] opa [N];
  logic [15:0] opb [N];
  bit pend [N];
  logic [15:0] e_mul_a = '0, e_mul_b = '0;
  logic [N-1:0] e_rsp_v = '0;
  int e_rsp_id = 0;
  int e_rsp_d = 0;
  bit e_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (pend[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  function automatic logic [15:0] rand_op();
    int s;
    s = int'($urandom_range(7));
    return s == 0 ? 16'h8000 : s == 1 ? 16'h7fff : s == 2 ? 16'hffff : s == 3 ? 16'h0000 : 16'($urandom);
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_a[16*i +: 16] = opa[i];
      req_b[16*i +: 16] = opb[i];
    end
  endtask

  task automatic model_edge();
    edge_n++;
    if (exp_gnt >= 0) begin
      acc_e.push_back(edge_n);
      acc_i.push_back(exp_gnt);
      acc_p.push_back(int'($signed(opa[exp_gnt])) * int'($signed(opb[exp_gnt])));
      e_mul_a = opa[exp_gnt];
      e_mul_b = opb[exp_gnt];
      glog.push_back(exp_gnt);
      pend[exp_gnt] = 1'b0;
      ptr_m = (exp_gnt + 1) % N;
    end else begin
      e_mul_a = '0;
      e_mul_b = '0;
    end
    e_rsp_v = '0;
    while (acc_e.size() > 0 && acc_e[0] <= edge_n - (L + 1)) begin
      if (acc_e[0] == edge_n - (L + 1)) begin
        e_rsp_v = N'(1) << acc_i[0];
        e_rsp_id = acc_i[0];
        e_rsp_d = acc_p[0];
      end
      void'(acc_e.pop_front());
      void'(acc_i.pop_front());
      void'(acc_p.pop_front());
    end
    e_busy = acc_e.size() > 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("mul_a", mul_a, e_mul_a);
    chk("mul_b", mul_b, e_mul_b);
    chk("rsp_valid", rsp_valid, e_rsp_v);
    chk("rsp_id", rsp_id, e_rsp_id);
    chk("rsp_data", rsp_data, e_rsp_d);
    chk("busy", busy, e_busy);
    if (rsp_valid != 0) begin
      rl_e.push_back(edge_n);
      rl_id.push_back(int'(rsp_id));
      rl_d.push_back(int'(rsp_data));
      rl_v.push_back(int'(rsp_valid));
    end
    for (int i = 0; i < N; i++) begin
      if (pend[i] && int'($urandom_range(99)) < drop) pend[i] = 1'b0;
      else if (!pend[i] && int'($urandom_range(99)) < load) begin
        pend[i] = 1'b1;
        opa[i] = rand_op();
        opb[i] = rand_op();
      end
    end
    apply();
    #1;
    exp_gnt = pick();
    chk("req_ready", req_ready, exp_gnt < 0 ? '0 : N'(1) << exp_gnt);
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    apply();
    #1;
    ptr_m = 0;
    exp_gnt = -1;
    acc_e.delete(); acc_i.delete(); acc_p.delete();
    e_mul_a = '0; e_mul_b = '0; e_rsp_v = '0; e_rsp_id = 0; e_rsp_d = 0; e_busy = 1'b0;
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_edge();
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    pend[i] = 1'b1;
    opa[i] = a;
    opb[i] = b;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  int r0, g0, e0;

  initial begin
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; opa[i] = '0; opb[i] = '0; end
    do_reset();

    // contention: all four at once from ptr 0
    r0 = rl_e.size(); g0 = glog.size(); e0 = edge_n + 1;
    set_req(0, 16'(-5), 16'd4);
    set_req(1, 16'(-8), 16'(-6));
    set_req(2, 16'd15, 16'd0);
    set_req(3, 16'(-1), 16'd32767);
    idle(14);
    for (int k = 0; k < 4; k++) chk("cont_grant", glog[g0+k], k);
    chk("cont_count", rl_e.size() - r0, 4);
    chk("cont_d0", rl_d[r0], 32'(-20));
    chk("cont_d1", rl_d[r0+1], 32'd48);
    chk("cont_d2", rl_d[r0+2], 32'd0);
    chk("cont_d3", rl_d[r0+3], 32'(-32767));
    for (int k = 0; k < 4; k++) begin
      chk("cont_id", rl_id[r0+k], k);
      chk("cont_edge", rl_e[r0+k], e0 + 7 + k);
    end

    // single request latency
    r0 = rl_e.size(); e0 = edge_n + 1;
    set_req(0, 16'd7, 16'd3);
    idle(10);
    chk("single_count", rl_e.size() - r0, 1);
    chk("single_data", rl_d[r0], 32'd21);
    chk("single_valid", rl_v[r0], 32'b0001);
    chk("single_edge", rl_e[r0], e0 + 7);

    // corner operands from requester 1
    r0 = rl_e.size();
    set_req(1, 16'h8000, 16'd1); cycle();
    set_req(1, 16'h7fff, 16'd1); cycle();
    set_req(1, 16'h8000, 16'h8000); cycle();
    idle(10);
    chk("corner_count", rl_e.size() - r0, 3);
    chk("corner0", rl_d[r0], 32'hffff8000);
    chk("corner1", rl_d[r0+1], 32'd32767);
    chk("corner2", rl_d[r0+2], 32'd1073741824);

    // fairness: 1 and 3 contend continuously with ptr at 2
    g0 = glog.size();
    for (int k = 0; k < 8; k++) begin
      if (!pend[1]) set_req(1, rand_op(), rand_op());
      if (!pend[3]) set_req(3, rand_op(), rand_op());
      cycle();
    end
    pend[1] = 1'b0; pend[3] = 1'b0;
    idle(10);
    for (int k = 0; k < 8; k++) chk("fair_grant", glog[g0+k], (k % 2 == 0) ? 3 : 1);

    // reset with three ops in flight
    set_req(0, 16'd11, 16'd3); set_req(2, 16'd5, 16'd5); set_req(3, 16'd9, 16'd9);
    idle(3);
    idle(2);
    do_reset();
    r0 = rl_e.size();
    idle(12);
    chk("rst_no_rsp", rl_e.size() - r0, 0);
    g0 = glog.size(); e0 = edge_n + 1;
    set_req(1, 16'd2, 16'd2); set_req(3, 16'd5, 16'd5);
    idle(12);
    chk("post_rst_grant", glog[g0], 1);
    chk("post_rst_data", rl_d[r0], 32'd4);
    chk("post_rst_id", rl_id[r0], 1);
    chk("post_rst_edge", rl_e[r0], e0 + 7);

    // idle stretch; ptr must stay where it was (0 after granting 3)
    r0 = rl_e.size(); g0 = glog.size();
    idle(20);
    chk("idle_rsp", rl_e.size() - r0, 0);
    chk("idle_grants", glog.size() - g0, 0);
    for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
    idle(1);
    chk("idle_ptr", glog[g0], 0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    idle(10);

    // randomized traffic
    drop = 5;
    for (int blk = 0; blk < 15; blk++) begin
      load = int'($urandom_range(100));
      idle(200);
      if (blk == 7) do_reset();
    end
    drop = 0; load = 0;
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one pipelined signed 16x16 Wallace-tree multiplier between NUM_REQ independent requesters. Accepts at most one operand pair per cycle, drives the multiplier operand inputs, and carries a requester tag through a shift register matched to the multiplier latency. Returns each 32-bit product to its originator. Sits between requester blocks (filters, MAC controllers) and the single multiplier instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MUL_LATENCY, 6, cycles from operands on mul_a/mul_b to product on mul_c
- ID_W, 2, requester index width, equals clog2(NUM_REQ)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (grant), one-hot or zero
- req_a  in  16*NUM_REQ  signed operand A, requester i in bits [16i+15:16i]
- req_b  in  16*NUM_REQ  signed operand B, same packing
- mul_a  out  16  registered operand A to multiplier
- mul_b  out  16  registered operand B to multiplier
- mul_c  in  32  signed product from multiplier
- rsp_valid  out  NUM_REQ  one-hot, single-cycle result strobe
- rsp_id  out  ID_W  index of requester owning rsp_data
- rsp_data  out  32  signed product
- busy  out  1  high while any tag is in flight

## Operation
- Arbitration: combinational round-robin over req_valid, search starting at pointer ptr; req_ready = one-hot grant of first valid found; zero if no req_valid.
- Accept = req_valid[i] & req_ready[i]; at most one per cycle. Requesters hold req_a/req_b stable while valid and not ready.
- ptr resets to 0; on accept from i, ptr <= (i+1) mod NUM_REQ; unchanged when idle.
- On accept edge: mul_a/mul_b <= granted operands; tag stage 0 <= {1, i}. No accept: mul_a/mul_b <= 0, tag stage 0 valid <= 0.
- Tag pipeline: MUL_LATENCY+1 stages (stage 0 aligned with mul_a/mul_b, stage MUL_LATENCY aligned with mul_c), shifts every cycle, never stalls.
- Response register: when final tag valid, rsp_data <= mul_c, rsp_id <= tag id, rsp_valid <= one-hot(tag id); otherwise rsp_valid <= 0, rsp_data and rsp_id hold.
- No response backpressure: requesters must consume rsp_valid the cycle it is high.
- busy = OR of all tag valid bits (combinational).
- Products are full-precision signed, no rounding or saturation (-32768 * -32768 = 1073741824).

## Timing
- Reset (rst low, async): req_ready combinationally follows ptr=0; mul_a=0, mul_b=0, all tag valid=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Latency: accept on edge E0 -> rsp_valid high for exactly one cycle after edge E0+MUL_LATENCY+1 (7 edges at default).
- Throughput: one product per cycle; back-to-back accepts return back-to-back responses in accept order.
- Simultaneous valids: exactly one granted; with all NUM_REQ valid continuously, grants rotate 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 cycles.
- Requester dropping valid before grant: no accept, ptr unchanged.
- Reset mid-operation: all in-flight tags discarded, no rsp_valid for them after reset release even though mul_c may still present stale products; first post-reset grant goes to lowest valid index.
- ptr wrap: grant to NUM_REQ-1 sets ptr to 0.

## Test plan
- Single request: req 0 sends 7 x 3 at edge E0 -> rsp_valid=0001, rsp_id=0, rsp_data=21 after edge E0+7, one cycle only; busy high E0..E0+6.
- Contention: all four valid with (-5,4),(-8,-6),(15,0),(-1,32767) -> grants 0,1,2,3 on consecutive edges; responses -20, 48, 0, -32767 on consecutive cycles with rsp_id 0,1,2,3.
- Fairness: req 1 and 3 valid continuously for 8 cycles with ptr=2 -> grant order 3,1,3,1,...; no two consecutive grants to same requester.
- Corner operands: (-32768,1) -> -32768; (32767,1) -> 32767; (-32768,-32768) -> 1073741824.
- Reset mid-flight: accept three ops, assert rst low 2 cycles after last accept -> all outputs zero immediately, no rsp_valid for those ops afterward; new 2 x 2 after release returns 4 with correct latency.
- Idle: no req_valid for 20 cycles -> req_ready=0, mul_a=mul_b=0, rsp_valid=0, busy=0, ptr unchanged.
